// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 8-bit instruction words (plus a Load immediate) from a synchronous
// ROM, launches each on the control unit with a one-cycle Run pulse and paces on Done.
module instr_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              Done,
  output logic              Run,
  output logic [1:0]        Fun,
  output logic [1:0]        Rx,
  output logic [1:0]        Ry,
  output logic [7:0]        Din,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_IMM,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_HALT,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        fun_q, fun_d;
  logic [1:0]        rx_q, rx_d;
  logic [1:0]        ry_q, ry_d;
  logic [7:0]        din_q, din_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;

  logic [1:0] instr_fun;
  logic [1:0] instr_rx;
  logic [1:0] instr_ry;
  logic       instr_halt;
  logic       unused_rsvd;
  logic       timer_expired;

  assign instr_fun     = imem_rdata[7:6];
  assign instr_rx      = imem_rdata[5:4];
  assign instr_ry      = imem_rdata[3:2];
  assign instr_halt    = imem_rdata[1];
  assign unused_rsvd   = imem_rdata[0];
  assign timer_expired = (timer_q == TIMER_LAST);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    timer_d = timer_q;
    fun_d   = fun_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    din_d   = din_q;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // A halt word leaves PC on itself and keeps the last operation's fields visible.
        if (instr_halt) begin
          state_d = S_HALT;
        end else begin
          fun_d   = instr_fun;
          rx_d    = instr_rx;
          ry_d    = instr_ry;
          pc_d    = pc_q + 1'b1;
          state_d = (instr_fun == 2'b00) ? S_FETCH_IMM : S_ISSUE;
        end
      end
      S_FETCH_IMM: state_d = S_IMM;
      S_IMM: begin
        din_d   = imem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (Done) begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end else if (timer_expired) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!Done) begin
          state_d = S_FETCH;
        end else if (timer_expired) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    run_d    = (state_d == S_ISSUE);
    halted_d = (state_d == S_HALT);
    error_d  = (state_d == S_ERROR);
    busy_d   = !(state_d inside {S_IDLE, S_HALT, S_ERROR});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      timer_q  <= '0;
      fun_q    <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      timer_q  <= timer_d;
      fun_q    <= fun_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  assign imem_addr = pc_q;
  assign Run       = run_q;
  assign Fun       = fun_q;
  assign Rx        = rx_q;
  assign Ry        = ry_q;
  assign Din       = din_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign error     = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed and random programs checked against an
// instruction-level model that walks the ROM and predicts the cycle of every Run/halt.
module tb_instr_sequencer;

  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              Done;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_rdata;
  logic              Run;
  logic [1:0]        Fun;
  logic [1:0]        Rx;
  logic [1:0]        Ry;
  logic [7:0]        Din;
  logic              busy;
  logic              halted;
  logic              error;

  logic [7:0] rom [DEPTH];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  // Architectural view of the sequencer kept by the model.
  int         m_pc;
  logic [1:0] m_fun;
  logic [1:0] m_rx;
  logic [1:0] m_ry;
  logic [7:0] m_din;

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .Done      (Done),
    .Run       (Run),
    .Fun       (Fun),
    .Rx        (Rx),
    .Ry        (Ry),
    .Din       (Din),
    .busy      (busy),
    .halted    (halted),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata <= rom[imem_addr];
    cyc        <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_fields(input string tag, input logic [1:0] f, input logic [1:0] x,
                            input logic [1:0] y);
    chk({tag, ".Fun"}, 32'(Fun), 32'(f));
    chk({tag, ".Rx"}, 32'(Rx), 32'(x));
    chk({tag, ".Ry"}, 32'(Ry), 32'(y));
  endtask

  // Asserts reset for one edge from the current cycle and checks the reset values.
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    Done  = 1'b0;
    tick();
    chk("rst.Run", 32'(Run), 0);
    chk_fields("rst", 2'b00, 2'b00, 2'b00);
    chk("rst.Din", 32'(Din), 0);
    chk("rst.addr", 32'(imem_addr), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.error", 32'(error), 0);
    reset = 1'b0;
    m_fun = '0;
    m_rx  = '0;
    m_ry  = '0;
    m_din = '0;
  endtask

  // Starts execution from IDLE/HALT and follows the program op by op. Done is driven
  // as a control unit with a random rise delay d and high length l.
  task automatic run_prog(input string name, input int max_ops, input int fixed_l,
                          output bit did_halt);
    int         f, ev, c, d, l, ops, fetch_pc;
    logic [7:0] w;
    logic [1:0] p_fun, p_rx, p_ry;
    logic [7:0] p_din;
    bit         fin;
    did_halt = 1'b0;
    ops      = 0;
    fin      = 1'b0;
    m_pc     = 0;
    start    = 1'b1;
    Done     = 1'b0;
    f        = cyc + 1;
    while (!fin) begin
      p_fun    = m_fun;
      p_rx     = m_rx;
      p_ry     = m_ry;
      p_din    = m_din;
      fetch_pc = m_pc;
      w        = rom[m_pc];
      if (w[1]) begin
        ev = f + 2;
      end else begin
        m_fun = w[7:6];
        m_rx  = w[5:4];
        m_ry  = w[3:2];
        m_pc  = (m_pc + 1) % DEPTH;
        if (w[7:6] == 2'b00) begin
          m_din = rom[m_pc];
          m_pc  = (m_pc + 1) % DEPTH;
          ev    = f + 4;
        end else begin
          ev = f + 2;
        end
      end
      while (cyc < ev - 1) begin
        tick();
        start = 1'($urandom_range(0, 1));
        Done  = 1'($urandom_range(0, 1));
        chk({name, ".run_low"}, 32'(Run), 0);
        chk({name, ".busy"}, 32'(busy), 1);
        chk({name, ".din_hold"}, 32'(Din), 32'(p_din));
        if (cyc == f) chk({name, ".fetch_addr"}, 32'(imem_addr), 32'(fetch_pc));
        if (cyc <= f + 1) chk_fields({name, ".old"}, p_fun, p_rx, p_ry);
      end
      tick();
      start = 1'b0;
      Done  = 1'b0;
      if (w[1]) begin
        chk({name, ".halted"}, 32'(halted), 1);
        chk({name, ".halt_busy"}, 32'(busy), 0);
        chk({name, ".halt_run"}, 32'(Run), 0);
        chk({name, ".halt_pc"}, 32'(imem_addr), 32'(fetch_pc));
        chk_fields({name, ".halt"}, p_fun, p_rx, p_ry);
        $display("cycle %0d %s: halt at pc %0d", cyc, name, fetch_pc);
        did_halt = 1'b1;
        fin      = 1'b1;
      end else begin
        c = cyc;
        ops++;
        chk({name, ".run"}, 32'(Run), 1);
        chk({name, ".pc"}, 32'(imem_addr), 32'(m_pc));
        chk({name, ".Din"}, 32'(Din), 32'(m_din));
        chk_fields({name, ".issue"}, m_fun, m_rx, m_ry);
        d = $urandom_range(0, 3);
        l = (fixed_l > 0) ? fixed_l : $urandom_range(1, 5);
        $display("cycle %0d %s: op%0d fun=%0d rx=%0d ry=%0d din=%02h next_pc=%0d done(d=%0d,l=%0d)",
                 cyc, name, ops, m_fun, m_rx, m_ry, m_din, m_pc, d, l);
        for (int j = c + 1; j <= c + d + l + 1; j++) begin
          tick();
          Done  = (j >= c + 1 + d) && (j <= c + d + l);
          start = 1'($urandom_range(0, 1));
          chk({name, ".run_once"}, 32'(Run), 0);
          chk({name, ".wait_busy"}, 32'(busy), 1);
          chk({name, ".Din_hold"}, 32'(Din), 32'(m_din));
          chk_fields({name, ".hold"}, m_fun, m_rx, m_ry);
        end
        f = c + d + l + 2;
        if (ops >= max_ops) fin = 1'b1;
      end
    end
  endtask

  // Starts from IDLE with rom[0] holding a non-halt op and stops in its ISSUE cycle.
  task automatic issue_first(input string name, output int c);
    start = 1'b1;
    Done  = 1'b0;
    tick();
    start = 1'b0;
    repeat ((rom[0][7:6] == 2'b00) ? 4 : 2) tick();
    c = cyc;
    chk({name, ".run"}, 32'(Run), 1);
  endtask

  initial begin
    bit         h;
    int         c;
    logic [7:0] w;
    reset = 1'b1;
    start = 1'b0;
    Done  = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;
    tick();
    tick();
    do_reset();
    repeat (3) begin
      tick();
      chk("idle.busy", 32'(busy), 0);
      chk("idle.run", 32'(Run), 0);
    end

    // Load R1,0x5A then halt; halt leaves PC on the halt word.
    rom[0] = 8'h10; rom[1] = 8'h5A; rom[2] = 8'h02;
    run_prog("load", 4, 3, h);

    // Add R0,R2 with Done high 3 cycles, started from HALT.
    rom[0] = 8'h88; rom[1] = 8'h02;
    run_prog("add", 4, 3, h);
    do_reset();

    // Done never rises: error exactly TIMEOUT cycles after WAIT_BUSY entry.
    rom[0] = 8'h7C;
    issue_first("tmo", c);
    for (int j = c + 1; j <= c + TIMEOUT + 1; j++) begin
      tick();
      start = 1'($urandom_range(0, 1));
      Done  = 1'b0;
      chk("tmo.run", 32'(Run), 0);
      chk("tmo.error", 32'(error), (j <= c + TIMEOUT) ? 1'b0 : 1'b1);
    end
    chk("tmo.busy", 32'(busy), 0);
    repeat (3) begin
      tick();
      start = 1'b1;
      chk("tmo.sticky", 32'(error), 1);
      chk("tmo.run_idle", 32'(Run), 0);
      chk("tmo.not_busy", 32'(busy), 0);
    end
    do_reset();

    // Done stuck high: error after TIMEOUT cycles in WAIT_DONE.
    issue_first("stuck", c);
    Done = 1'b1;
    for (int j = c + 1; j <= c + TIMEOUT + 2; j++) begin
      tick();
      Done = 1'b1;
      chk("stuck.run", 32'(Run), 0);
      chk("stuck.error", 32'(error), (j <= c + TIMEOUT + 1) ? 1'b0 : 1'b1);
    end
    do_reset();

    // Reset during WAIT_DONE of a Load, then restart at address 0.
    rom[0] = 8'h30; rom[1] = 8'hC3;
    issue_first("rmid", c);
    tick(); Done = 1'b1;
    tick(); Done = 1'b1;
    tick();
    chk("rmid.Din", 32'(Din), 32'hC3);
    chk("rmid.Rx", 32'(Rx), 3);
    do_reset();
    rom[0] = 8'h5C; rom[1] = 8'h02;
    run_prog("restart", 4, 0, h);

    // Load at the top address takes its immediate from address 0 and PC wraps to 1.
    rom[0] = 8'hA5;
    for (int i = 1; i < DEPTH - 1; i++) begin
      w      = 8'($urandom_range(0, 255));
      w[7:6] = 2'($urandom_range(1, 3));
      w[1]   = 1'b0;
      rom[i] = w;
    end
    rom[DEPTH - 1] = 8'h00;
    run_prog("wrap", DEPTH + 2, 0, h);
    do_reset();

    // Random programs, each started from HALT or after a reset.
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) w[1] = 1'b0;
        rom[i] = w;
      end
      run_prog("rand", 12, 0, h);
      if (!h) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
